// File: rtl/screen_pkg.sv
// Shared screen geometry, write-port widths and the box_mover state encoding.
// Everything that talks to the pixel framebuffer imports this package so the
// x/y/colour widths agree across the sprite engine and the write-port interface.
package screen_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int BOX      = 4;

   localparam int COL_W = 3;
   localparam int X_W   = 8;
   localparam int Y_W   = 7;

   typedef enum logic [2:0] {
      S_START  = 3'd0,
      S_IDLE   = 3'd1,
      S_ERASE  = 3'd2,
      S_UPDATE = 3'd3,
      S_DRAW   = 3'd4
   } state_t;

   // Bits needed for one axis of the sprite scan (BOX is a power of two).
   function automatic int box_off_w(input int side);
      return $clog2(side);
   endfunction

endpackage

// File: rtl/box_mover_if.sv
// Framebuffer / VGA adapter write port.
//   x, y    : pixel address
//   colour  : pixel colour
//   plot    : write strobe; the framebuffer samples x/y/colour on the next edge
// master drives the port (box_mover), slave is the framebuffer side.
interface box_mover_if;
   import screen_pkg::*;

   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [COL_W-1:0] colour;
   logic             plot;

   modport master (output x, y, colour, plot);
   modport slave  (input  x, y, colour, plot);

endinterface

// File: rtl/box_scan_counter.sv
// Pixel scan counter for a square sprite.
// Counts row-major over the BOX x BOX sprite: the low half of the count is the
// x offset, the high half the y offset. done is high on the last pixel.
// Ports:
//   clock, resetn : clock, synchronous active-low reset
//   clear         : force count to zero (wins over enable)
//   enable        : advance one pixel
//   done          : count is at its final value
//   x_off, y_off  : current pixel offset inside the sprite
module box_scan_counter #(
   parameter int OFF_W = 2
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             clear,
   input  logic             enable,
   output logic             done,
   output logic [OFF_W-1:0] x_off,
   output logic [OFF_W-1:0] y_off
);

   localparam int CW = 2 * OFF_W;

   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign done  = &cnt;
   assign x_off = cnt[OFF_W-1:0];
   assign y_off = cnt[CW-1:OFF_W];

endmodule

// File: rtl/box_mover.sv
// Bouncing square sprite engine, consumer end of the frame-rate tick chain.
// On each move_tick it erases the sprite, steps it one pixel diagonally with
// edge bounce, redraws it, then pulses sync_clear to realign the tick chain.
// Ports:
//   clock, resetn : clock, synchronous active-low reset
//   enable        : 1 = FSM advances, 0 = freeze (no plots, no sync_clear)
//   move_tick     : one-cycle move request; dropped unless IDLE
//   colour_in     : sprite colour, sampled when leaving START and in UPDATE
//   fb            : framebuffer write port (x, y, colour, plot)
//   busy          : state is not IDLE
//   sync_clear    : one-cycle pulse in the first IDLE cycle after a redraw
//
// state  | meaning
// -------+---------------------------------------------------------
// START  | after reset; draws the sprite at its reset position
// IDLE   | waiting for move_tick
// ERASE  | scanning the sprite with the background colour
// UPDATE | stepping position and direction, sampling sprite colour
// DRAW   | scanning the sprite with the sprite colour
module box_mover #(
   parameter int                         SCREEN_W = screen_pkg::SCREEN_W,
   parameter int                         SCREEN_H = screen_pkg::SCREEN_H,
   parameter int                         BOX      = screen_pkg::BOX,
   parameter int                         X0       = 0,
   parameter int                         Y0       = 0,
   parameter logic [screen_pkg::COL_W-1:0] BG     = '0
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic                         enable,
   input  logic                         move_tick,
   input  logic [screen_pkg::COL_W-1:0] colour_in,
   box_mover_if.master                  fb,
   output logic                         busy,
   output logic                         sync_clear
);

   localparam int X_W   = screen_pkg::X_W;
   localparam int Y_W   = screen_pkg::Y_W;
   localparam int COL_W = screen_pkg::COL_W;
   localparam int OFF_W = screen_pkg::box_off_w(BOX);

   // Top-left corner limits that keep the whole sprite on screen.
   localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - BOX);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - BOX);

   screen_pkg::state_t state, state_next;

   logic [X_W-1:0]   px;
   logic [Y_W-1:0]   py;
   logic             dx, dy;
   logic [COL_W-1:0] dcol;
   logic             sync_q;

   logic             scanning;
   logic             scan_done;
   logic [OFF_W-1:0] x_off, y_off;

   assign scanning = (state == screen_pkg::S_ERASE) || (state == screen_pkg::S_DRAW);

   // Count is cleared outside the scan states so each scan starts at pixel 0.
   box_scan_counter #(.OFF_W(OFF_W)) u_scan (
      .clock  (clock),
      .resetn (resetn),
      .clear  (!scanning),
      .enable (enable && scanning),
      .done   (scan_done),
      .x_off  (x_off),
      .y_off  (y_off)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= screen_pkg::S_START;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      fb.plot    = 1'b0;
      fb.colour  = BG;
      fb.x       = px + X_W'(x_off);
      fb.y       = py + Y_W'(y_off);
      busy       = (state != screen_pkg::S_IDLE);
      sync_clear = sync_q && enable;

      if (enable) begin
         case (state)
            screen_pkg::S_START:  state_next = screen_pkg::S_DRAW;
            screen_pkg::S_IDLE:   if (move_tick) state_next = screen_pkg::S_ERASE;
            screen_pkg::S_ERASE:  begin
               fb.plot = 1'b1;
               if (scan_done) state_next = screen_pkg::S_UPDATE;
            end
            screen_pkg::S_UPDATE: state_next = screen_pkg::S_DRAW;
            screen_pkg::S_DRAW:   begin
               fb.plot   = 1'b1;
               fb.colour = dcol;
               if (scan_done) state_next = screen_pkg::S_IDLE;
            end
            default:              state_next = screen_pkg::S_START;
         endcase
      end

      if (state == screen_pkg::S_DRAW) begin
         fb.colour = dcol;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         px     <= X_W'(X0);
         py     <= Y_W'(Y0);
         dx     <= 1'b1;
         dy     <= 1'b1;
         dcol   <= BG;
         sync_q <= 1'b0;
      end else begin
         sync_q <= enable && (state == screen_pkg::S_DRAW) && scan_done;

         if (enable && (state == screen_pkg::S_START || state == screen_pkg::S_UPDATE)) begin
            dcol <= colour_in;
         end

         // x and y bounce independently, so a corner hit flips both at once.
         if (enable && state == screen_pkg::S_UPDATE) begin
            if (dx && px == X_MAX) begin
               dx <= 1'b0;
               px <= px - X_W'(1);
            end else if (!dx && px == '0) begin
               dx <= 1'b1;
               px <= X_W'(1);
            end else if (dx) begin
               px <= px + X_W'(1);
            end else begin
               px <= px - X_W'(1);
            end

            if (dy && py == Y_MAX) begin
               dy <= 1'b0;
               py <= py - Y_W'(1);
            end else if (!dy && py == '0) begin
               dy <= 1'b1;
               py <= Y_W'(1);
            end else if (dy) begin
               py <= py + Y_W'(1);
            end else begin
               py <= py - Y_W'(1);
            end
         end
      end
   end

endmodule
